song_reader: RTL and testbench
==============================

SONG_READER -- requirements
Module: song_reader

Interface
REQ-001 Parameter NOTE_AW, default 5, log2 of entries per song (32 entries per song).
REQ-002 Parameter SONG_W, default 2, song-select width (4 songs).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 play  input  1  level; high permits issuing entries, low pauses issue.
REQ-006 song  input  SONG_W  selected song; sampled every cycle.
REQ-007 note_done  input  1  one-cycle pulse from the arranger; current entry consumed.
REQ-008 load_new_note  output  1  one-cycle strobe; note_to_load valid this cycle.
REQ-009 note_to_load  output  16  entry: [15] advance flag, [14:9] note, [8:3] duration in beats, [2:0] zero.
REQ-010 song_done  output  1  level; high while the current song has ended.
REQ-011 entry_index  output  NOTE_AW  index of the entry being fetched or awaited.

Function
REQ-012 States SHALL be IDLE, FETCH, ISSUE, WAIT, DONE.
REQ-013 IDLE SHALL go to FETCH on the first cycle play=1, latching song.
REQ-014 FETCH SHALL present address {song_latched, entry_index} to the ROM; registered ROM data SHALL be valid the next cycle; FETCH SHALL then go to ISSUE.
REQ-015 ISSUE with play=1 and nonzero data SHALL assert load_new_note for exactly one cycle, drive note_to_load = ROM data with [2:0] forced to 0, and go to WAIT.
REQ-016 ISSUE with play=0 SHALL hold ISSUE with no strobe until play=1.
REQ-017 ROM data 16'h0000 is the end marker; ISSUE SHALL go to DONE with no strobe.
REQ-018 note_to_load SHALL hold its value from one strobe until the next strobe.
REQ-019 WAIT SHALL ignore play and leave only on note_done.
REQ-020 On note_done in WAIT: if entry_index = 2^NOTE_AW-1, go to DONE; otherwise increment entry_index and go to FETCH.
REQ-021 note_done outside WAIT SHALL be ignored.
REQ-022 At most one load_new_note SHALL be outstanding: no strobe between a strobe and its note_done.
REQ-023 DONE SHALL hold song_done=1 and issue no strobes.
REQ-024 A song input differing from the latched song in any state except IDLE SHALL, on the next edge, latch the new song, clear entry_index, clear song_done, and go to FETCH.
REQ-025 If the song change coincides with note_done, the song change SHALL win and note_done SHALL be dropped.
REQ-026 Latency from play rising in IDLE to the first load_new_note SHALL be 3 cycles: IDLE->FETCH->ISSUE, with the strobe in ISSUE.

Reset
REQ-027 reset SHALL force IDLE, entry_index=0, latched song=0, load_new_note=0, note_to_load=0, song_done=0.
REQ-028 reset SHALL take priority over every other input, including mid-WAIT; an outstanding entry SHALL be abandoned.

Structure
REQ-029 A shared package SHALL hold the state encoding, the entry field positions (ADV_BIT=15, NOTE_MSB/LSB=14/9, DUR_MSB/LSB=8/3), and END_MARKER=16'h0000.
REQ-030 The ROM SHALL be a sub-module song_rom: registered output, 1-cycle latency, depth 2^(SONG_W+NOTE_AW), width 16.

Verification
REQ-031 Song 0 = {16'h55F8, 16'h8018, 0}; reset, then play=1 -> strobe with 16'h55F8 3 cycles later; note_done -> strobe with 16'h8018 3 cycles later; note_done -> song_done=1, no further strobe.
REQ-032 play=0 while in FETCH -> no strobe while play=0; play=1 -> strobe on the next cycle, with the same entry.
REQ-033 Pulse note_done 5 cycles after a strobe while in WAIT with play=0 -> entry_index increments and the next entry is not issued until play=1.
REQ-034 Song full of nonzero entries; 32 note_done pulses -> 32 strobes, indices 0..31; song_done=1 after the 32nd pulse; entry_index does not wrap.
REQ-035 Change song 0->2 in WAIT, together with note_done -> entry_index=0, first strobe carries song 2 entry 0, and the dropped note_done issues no extra strobe.
REQ-036 Assert reset mid-WAIT -> next cycle all outputs 0, state IDLE; a late note_done is ignored.

Source files
------------

// File: rtl/song_reader_pkg.sv
// Shared definitions for the song reader: FSM encoding, entry field layout
// and the ROM contents generator.
package song_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  // Entry layout: [15] advance, [14:9] note, [8:3] duration, [2:0] zero.
  localparam int ADV_BIT  = 15;
  localparam int NOTE_MSB = 14;
  localparam int NOTE_LSB = 9;
  localparam int DUR_MSB  = 8;
  localparam int DUR_LSB  = 3;

  localparam logic [15:0] END_MARKER = 16'h0000;

  // ROM contents for song s, entry e.
  //   song 0: two notes then end marker
  //   song 1: every entry a nonzero note (note = e+1, duration 2, advance)
  //   song 2: two notes (first has stray low bits) then end marker
  //   song 3: empty song
  function automatic logic [15:0] rom_init(input int s, input int e);
    logic [15:0] w;
    w = END_MARKER;
    case (s)
      0: begin
        if (e == 0)      w = 16'h55F8;
        else if (e == 1) w = 16'h8018;
      end
      1: begin
        w[ADV_BIT]           = 1'b1;
        w[NOTE_MSB:NOTE_LSB] = 6'(e + 1);
        w[DUR_MSB:DUR_LSB]   = 6'd2;
      end
      2: begin
        if (e == 0)      w = 16'h4A17;
        else if (e == 1) w = 16'h4C20;
      end
      default: ;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/song_reader_rom.sv
// Song ROM: one table holding every song back to back, registered read
// with one cycle of latency.
module song_rom
  import song_reader_pkg::*;
#(
  parameter int NOTE_AW = 5,
  parameter int SONG_W  = 2
) (
  input  logic                      clk,
  input  logic [SONG_W+NOTE_AW-1:0] addr_i,
  output logic [15:0]               data_o
);

  localparam int DEPTH = 1 << (SONG_W + NOTE_AW);

  logic [15:0] rom_mem [DEPTH];
  logic [15:0] data_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_init
    localparam int S = gi >> NOTE_AW;
    localparam int E = gi & ((1 << NOTE_AW) - 1);
    assign rom_mem[gi] = rom_init(S, E);
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    data_q <= rom_mem[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/song_reader.sv
// Song reader: walks the entries of the selected song, hands each one to
// the arranger as a one-cycle strobe and waits for it to be consumed.
module song_reader
  import song_reader_pkg::*;
#(
  parameter int NOTE_AW = 5,
  parameter int SONG_W  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               play,
  input  logic [SONG_W-1:0]  song,
  input  logic               note_done,
  output logic               load_new_note,
  output logic [15:0]        note_to_load,
  output logic               song_done,
  output logic [NOTE_AW-1:0] entry_index
);

  state_e             state_q;
  logic [SONG_W-1:0]  song_q;
  logic [NOTE_AW-1:0] idx_q;
  logic               load_q;
  logic [15:0]        note_q;
  logic               done_q;
  logic [15:0]        rom_data;

  song_rom #(
    .NOTE_AW(NOTE_AW),
    .SONG_W (SONG_W)
  ) u_rom (
    .clk   (clk),
    .addr_i({song_q, idx_q}),
    .data_o(rom_data)
  );

  // Reader FSM; a song change outside IDLE restarts the new song and
  // overrides anything else happening that cycle, including note_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      song_q  <= '0;
      idx_q   <= '0;
      load_q  <= 1'b0;
      note_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      load_q <= 1'b0;
      if (state_q != ST_IDLE && song != song_q) begin
        song_q  <= song;
        idx_q   <= '0;
        done_q  <= 1'b0;
        state_q <= ST_FETCH;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (play) begin
              song_q  <= song;
              state_q <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            // Address is applied this cycle; data is valid in ISSUE.
            state_q <= ST_ISSUE;
          end
          ST_ISSUE: begin
            if (play) begin
              if (rom_data == END_MARKER) begin
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end else begin
                load_q  <= 1'b1;
                note_q  <= {rom_data[ADV_BIT:DUR_LSB], {DUR_LSB{1'b0}}};
                state_q <= ST_WAIT;
              end
            end
          end
          ST_WAIT: begin
            if (note_done) begin
              if (idx_q == {NOTE_AW{1'b1}}) begin
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end else begin
                idx_q   <= idx_q + 1'b1;
                state_q <= ST_FETCH;
              end
            end
          end
          ST_DONE: begin
            state_q <= ST_DONE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign load_new_note = load_q;
  assign note_to_load  = note_q;
  assign song_done     = done_q;
  assign entry_index   = idx_q;

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader: a cycle-by-cycle vector table plus
// hand-written multi-cycle sequences.
module tb_song_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        play = 1'b0;
  logic [1:0]  song = 2'd0;
  logic        note_done = 1'b0;
  logic        load_new_note;
  logic [15:0] note_to_load;
  logic        song_done;
  logic [4:0]  entry_index;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  song_reader #(
    .NOTE_AW(5),
    .SONG_W (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .play         (play),
    .song         (song),
    .note_done    (note_done),
    .load_new_note(load_new_note),
    .note_to_load (note_to_load),
    .song_done    (song_done),
    .entry_index  (entry_index)
  );

  typedef struct {
    logic        rst;
    logic        ply;
    logic [1:0]  sng;
    logic        nd;
    logic        ld;
    logic [15:0] note;
    logic        dn;
    logic [4:0]  idx;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rst, input logic ply, input logic [1:0] sng,
                              input logic nd, input logic ld, input logic [15:0] note,
                              input logic dn, input logic [4:0] idx);
    vec_t v;
    v.rst = rst; v.ply = ply; v.sng = sng; v.nd = nd;
    v.ld = ld; v.note = note; v.dn = dn; v.idx = idx;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  task automatic wait_strobe(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (load_new_note === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_done;
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int extra;
    logic [15:0] exp_note;

    // Song 0 walk: reset, latency, note hold, end marker, ignored note_done.
    vq.push_back(mk(1,0,0,0, 0,16'h0000,0,0));
    vq.push_back(mk(0,1,0,0, 0,16'h0000,0,0));
    vq.push_back(mk(0,1,0,0, 0,16'h0000,0,0));
    vq.push_back(mk(0,1,0,0, 1,16'h55F8,0,0));
    vq.push_back(mk(0,1,0,0, 0,16'h55F8,0,0));
    vq.push_back(mk(0,1,0,1, 0,16'h55F8,0,1));
    vq.push_back(mk(0,1,0,0, 0,16'h55F8,0,1));
    vq.push_back(mk(0,1,0,0, 1,16'h8018,0,1));
    vq.push_back(mk(0,1,0,1, 0,16'h8018,0,2));
    vq.push_back(mk(0,1,0,0, 0,16'h8018,0,2));
    vq.push_back(mk(0,1,0,0, 0,16'h8018,1,2));
    vq.push_back(mk(0,1,0,0, 0,16'h8018,1,2));
    vq.push_back(mk(0,1,0,1, 0,16'h8018,1,2));
    // Pause in FETCH/ISSUE, then a late note_done in WAIT with play low.
    vq.push_back(mk(1,0,0,0, 0,16'h0000,0,0));
    vq.push_back(mk(0,1,0,0, 0,16'h0000,0,0));
    vq.push_back(mk(0,0,0,0, 0,16'h0000,0,0));
    vq.push_back(mk(0,0,0,0, 0,16'h0000,0,0));
    vq.push_back(mk(0,0,0,0, 0,16'h0000,0,0));
    vq.push_back(mk(0,1,0,0, 1,16'h55F8,0,0));
    vq.push_back(mk(0,0,0,0, 0,16'h55F8,0,0));
    vq.push_back(mk(0,0,0,0, 0,16'h55F8,0,0));
    vq.push_back(mk(0,0,0,0, 0,16'h55F8,0,0));
    vq.push_back(mk(0,0,0,0, 0,16'h55F8,0,0));
    vq.push_back(mk(0,0,0,1, 0,16'h55F8,0,1));
    vq.push_back(mk(0,0,0,0, 0,16'h55F8,0,1));
    vq.push_back(mk(0,0,0,0, 0,16'h55F8,0,1));
    vq.push_back(mk(0,0,0,0, 0,16'h55F8,0,1));
    vq.push_back(mk(0,1,0,0, 1,16'h8018,0,1));

    foreach (vq[i]) begin
      reset = vq[i].rst; play = vq[i].ply; song = vq[i].sng; note_done = vq[i].nd;
      tick();
      chk($sformatf("vec%0d", i),
          {9'd0, load_new_note, note_to_load, song_done, entry_index},
          {9'd0, vq[i].ld, vq[i].note, vq[i].dn, vq[i].idx});
    end

    // Full song 1: 32 entries, no wrap of entry_index.
    reset = 1'b1; play = 1'b0; note_done = 1'b0; song = 2'd1;
    tick();
    reset = 1'b0; play = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wait_strobe(8, ok);
      chk($sformatf("full_strobe%0d", i), 32'(ok), 32'd1);
      exp_note = {1'b1, 6'(i + 1), 6'd2, 3'b000};
      chk($sformatf("full_note%0d", i), 32'(note_to_load), 32'(exp_note));
      chk($sformatf("full_idx%0d", i), 32'(entry_index), 32'(i));
      pulse_done();
    end
    chk("full_done", 32'(song_done), 32'd1);
    chk("full_idx_end", 32'(entry_index), 32'd31);
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (load_new_note === 1'b1) extra++;
    end
    chk("full_no_extra", 32'(extra), 32'd0);
    chk("full_idx_hold", 32'(entry_index), 32'd31);

    // Song change together with note_done in WAIT.
    reset = 1'b1; play = 1'b0; song = 2'd0;
    tick();
    reset = 1'b0; play = 1'b1;
    wait_strobe(8, ok);
    chk("chg_first_note", 32'(note_to_load), 32'h55F8);
    song = 2'd2; note_done = 1'b1;
    tick();
    note_done = 1'b0;
    chk("chg_idx_clear", {31'd0, load_new_note, entry_index}, 32'd0);
    wait_strobe(8, ok);
    chk("chg_strobe", 32'(ok), 32'd1);
    chk("chg_note_s2e0", 32'(note_to_load), 32'h4A10);
    chk("chg_idx0", 32'(entry_index), 32'd0);
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (load_new_note === 1'b1) extra++;
    end
    chk("chg_no_extra", 32'(extra), 32'd0);
    pulse_done();
    wait_strobe(8, ok);
    chk("chg_note_s2e1", 32'(note_to_load), 32'h4C20);
    chk("chg_idx1", 32'(entry_index), 32'd1);
    pulse_done();
    tick();
    tick();
    chk("s2_done", 32'(song_done), 32'd1);
    // Song change out of DONE clears song_done; empty song 3 ends at once.
    song = 2'd3;
    tick();
    chk("s3_done_clear", {30'd0, song_done, 1'b0} | 32'(entry_index), 32'd0);
    tick();
    tick();
    chk("s3_done", 32'(song_done), 32'd1);
    chk("s3_idx", 32'(entry_index), 32'd0);

    // Reset mid-WAIT abandons the entry; late note_done ignored.
    reset = 1'b1; play = 1'b0; song = 2'd0;
    tick();
    reset = 1'b0; play = 1'b1;
    wait_strobe(8, ok);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_outputs", {9'd0, load_new_note, note_to_load, song_done, entry_index}, 32'd0);
    play = 1'b0; note_done = 1'b1;
    tick();
    note_done = 1'b0;
    chk("rst_late_done", {9'd0, load_new_note, note_to_load, song_done, entry_index}, 32'd0);
    tick();
    chk("rst_idle_hold", {9'd0, load_new_note, note_to_load, song_done, entry_index}, 32'd0);
    play = 1'b1;
    tick();
    chk("rst_lat1", 32'(load_new_note), 32'd0);
    tick();
    chk("rst_lat2", 32'(load_new_note), 32'd0);
    tick();
    chk("rst_lat3", {15'd0, load_new_note, note_to_load}, {15'd0, 1'b1, 16'h55F8});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
